// File: rtl/sample_discriminator_multichannel_pkg.sv
// Shared types and default build parameters for the receive-side sample
// discriminator. tx_pkg only carries the trigger fan-in from the transmit side.

package tx_pkg;

    // Number of digital trigger lines routed over from the transmit chain
    localparam int CHANNELS = 3;

endpackage : tx_pkg

package rx_pkg;

    localparam int CHANNELS         = 2;
    localparam int SAMPLE_WIDTH     = 12;
    localparam int PARALLEL_SAMPLES = 2;
    localparam int HOLDOFF_WIDTH    = 16;
    localparam int TIMESTAMP_WIDTH  = 48;
    localparam int INDEX_WIDTH      = 32;

    // Per-channel capture window state
    typedef enum logic {
        DISC_IDLE   = 1'b0,
        DISC_ACTIVE = 1'b1
    } disc_state_t;

    // Width of a select field for n sources, never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rx_pkg

// File: rtl/sample_discriminator_multichannel_channel.sv
// One discriminator channel: signed hysteresis comparators, IDLE/ACTIVE window
// FSM with holdoff counter, forwarded-word index and the registered outputs.

module sample_discriminator_channel
    import rx_pkg::*;
#(
    parameter  int SAMPLE_WIDTH     = rx_pkg::SAMPLE_WIDTH,
    parameter  int PARALLEL_SAMPLES = rx_pkg::PARALLEL_SAMPLES,
    parameter  int HOLDOFF_WIDTH    = rx_pkg::HOLDOFF_WIDTH,
    parameter  int TIMESTAMP_WIDTH  = rx_pkg::TIMESTAMP_WIDTH,
    parameter  int INDEX_WIDTH      = rx_pkg::INDEX_WIDTH,
    localparam int DATA_WIDTH       = SAMPLE_WIDTH * PARALLEL_SAMPLES,
    localparam int REC_WIDTH        = TIMESTAMP_WIDTH + INDEX_WIDTH
) (
    input  logic                       adc_clk,
    input  logic                       adc_reset_n,
    input  logic                       adc_reset_state,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       data_in_valid,
    input  logic                       dig_trig,
    input  logic [SAMPLE_WIDTH-1:0]    threshold_low,
    input  logic [SAMPLE_WIDTH-1:0]    threshold_high,
    input  logic [HOLDOFF_WIDTH-1:0]   holdoff,
    input  logic                       analog_en,
    input  logic                       digital_en,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       data_out_valid,
    output logic [REC_WIDTH-1:0]       ts_out,
    output logic                       ts_out_valid
);

    disc_state_t              state;
    logic [HOLDOFF_WIDTH-1:0] cnt;
    logic [INDEX_WIDTH-1:0]   index;

    logic above_high;
    logic above_low;
    logic hi_hit;
    logic lo_hit;
    logic dig_hit;
    logic start;
    logic forward;

    // Any lane strictly above each threshold, compared as signed values
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        above_high = 1'b0;
        above_low  = 1'b0;
        for (int i = 0; i < PARALLEL_SAMPLES; i++) begin
            if ($signed(data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > $signed(threshold_high)) begin
                above_high = 1'b1;
            end
            if ($signed(data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > $signed(threshold_low)) begin
                above_low = 1'b1;
            end
        end
    end

    // An invalid word never counts as a hit of any kind
    assign hi_hit  = data_in_valid & analog_en  & above_high;
    assign lo_hit  = data_in_valid & analog_en  & above_low;
    assign dig_hit = data_in_valid & digital_en & dig_trig;

    assign start   = (state == DISC_IDLE) & (hi_hit | dig_hit);
    assign forward = data_in_valid & ((state == DISC_ACTIVE) | start);

    // Window FSM and holdoff counter; the counter only moves on valid words
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= DISC_IDLE;
            cnt   <= '0;
        end else if (adc_reset_state) begin
            state <= DISC_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                DISC_IDLE: begin
                    if (start) begin
                        state <= DISC_ACTIVE;
                        cnt   <= holdoff;
                    end
                end
                DISC_ACTIVE: begin
                    if (data_in_valid) begin
                        if (lo_hit | dig_hit) begin
                            cnt <= holdoff;
                        end else if (cnt == '0) begin
                            state <= DISC_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= DISC_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Registered outputs: gated data, window-start record and the word index
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            ts_out         <= '0;
            ts_out_valid   <= 1'b0;
            index          <= '0;
        end else if (adc_reset_state) begin
            data_out_valid <= 1'b0;
            ts_out_valid   <= 1'b0;
            index          <= '0;
        end else begin
            data_out_valid <= forward;
            ts_out_valid   <= start;
            if (forward) begin
                data_out <= data_in;
                index    <= index + 1'b1;
            end
            // The record carries the index of the first word of this window
            if (start) begin
                ts_out <= {timestamp, index};
            end
        end
    end

endmodule : sample_discriminator_channel

// File: rtl/sample_discriminator_multichannel.sv
// Multichannel sample discriminator top: owns the free-running timestamp and
// the per-channel digital trigger select, and instantiates one channel each.

module sample_discriminator_multichannel
    import rx_pkg::*;
#(
    parameter  int CHANNELS         = rx_pkg::CHANNELS,
    parameter  int TRIG_CHANNELS    = tx_pkg::CHANNELS,
    parameter  int SAMPLE_WIDTH     = rx_pkg::SAMPLE_WIDTH,
    parameter  int PARALLEL_SAMPLES = rx_pkg::PARALLEL_SAMPLES,
    parameter  int HOLDOFF_WIDTH    = rx_pkg::HOLDOFF_WIDTH,
    parameter  int TIMESTAMP_WIDTH  = rx_pkg::TIMESTAMP_WIDTH,
    parameter  int INDEX_WIDTH      = rx_pkg::INDEX_WIDTH,
    localparam int DATA_WIDTH       = SAMPLE_WIDTH * PARALLEL_SAMPLES,
    localparam int REC_WIDTH        = TIMESTAMP_WIDTH + INDEX_WIDTH,
    localparam int SRC_WIDTH        = sel_width(TRIG_CHANNELS)
) (
    input  logic                               adc_clk,
    input  logic                               adc_reset_n,
    input  logic                               adc_reset_state,
    input  logic [CHANNELS*DATA_WIDTH-1:0]     data_in,
    input  logic [CHANNELS-1:0]                data_in_valid,
    input  logic [TRIG_CHANNELS-1:0]           digital_trigger_in,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   threshold_low,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]   threshold_high,
    input  logic [CHANNELS*HOLDOFF_WIDTH-1:0]  holdoff,
    input  logic [CHANNELS-1:0]                analog_en,
    input  logic [CHANNELS-1:0]                digital_en,
    input  logic [CHANNELS*SRC_WIDTH-1:0]      digital_src,
    output logic [CHANNELS*DATA_WIDTH-1:0]     data_out,
    output logic [CHANNELS-1:0]                data_out_valid,
    output logic [CHANNELS*REC_WIDTH-1:0]      ts_out,
    output logic [CHANNELS-1:0]                ts_out_valid
);

    localparam int TRIG_PAD = 1 << SRC_WIDTH;

    logic [TIMESTAMP_WIDTH-1:0] timestamp;
    logic [TRIG_PAD-1:0]        trig_padded;
    logic [CHANNELS-1:0]        dig_sel;

    // Free-running timestamp, wraps naturally at its width
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            timestamp <= '0;
        end else if (adc_reset_state) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + 1'b1;
        end
    end

    // Pad the trigger bus to the full select range so every code indexes safely
    always_comb begin
        trig_padded                      = '0;
        trig_padded[TRIG_CHANNELS-1:0]   = digital_trigger_in;
    end

    // Per-channel trigger select; codes past the last trigger line select nothing
    always_comb begin
        dig_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(digital_src[c*SRC_WIDTH +: SRC_WIDTH]) < TRIG_CHANNELS) begin
                dig_sel[c] = trig_padded[digital_src[c*SRC_WIDTH +: SRC_WIDTH]];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        sample_discriminator_channel #(
            .SAMPLE_WIDTH     (SAMPLE_WIDTH),
            .PARALLEL_SAMPLES (PARALLEL_SAMPLES),
            .HOLDOFF_WIDTH    (HOLDOFF_WIDTH),
            .TIMESTAMP_WIDTH  (TIMESTAMP_WIDTH),
            .INDEX_WIDTH      (INDEX_WIDTH)
        ) u_ch (
            .adc_clk         (adc_clk),
            .adc_reset_n     (adc_reset_n),
            .adc_reset_state (adc_reset_state),
            .data_in         (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .data_in_valid   (data_in_valid[c]),
            .dig_trig        (dig_sel[c]),
            .threshold_low   (threshold_low[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .threshold_high  (threshold_high[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .holdoff         (holdoff[c*HOLDOFF_WIDTH +: HOLDOFF_WIDTH]),
            .analog_en       (analog_en[c]),
            .digital_en      (digital_en[c]),
            .timestamp       (timestamp),
            .data_out        (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .data_out_valid  (data_out_valid[c]),
            .ts_out          (ts_out[c*REC_WIDTH +: REC_WIDTH]),
            .ts_out_valid    (ts_out_valid[c])
        );
    end

endmodule : sample_discriminator_multichannel

// File: tb/tb_sample_discriminator_multichannel.sv
// Directed bench for the multichannel sample discriminator: a vector table on
// channel 0 plus hand-written sequences for reset, simultaneous starts and wrap.

module tb_sample_discriminator_multichannel;

    localparam int CH   = 2;
    localparam int TRIG = 3;
    localparam int SW   = 12;
    localparam int PS   = 2;
    localparam int DW   = SW * PS;
    localparam int HW   = 16;
    localparam int TSW  = 48;
    localparam int IW   = 32;
    localparam int REC  = TSW + IW;
    localparam int SRCW = 2;
    localparam int TSW_S = 4;
    localparam int REC_S = TSW_S + IW;

    logic                 adc_clk = 1'b0;
    logic                 adc_reset_n;
    logic                 adc_reset_state;
    logic [CH*DW-1:0]     data_in;
    logic [CH-1:0]        data_in_valid;
    logic [TRIG-1:0]      digital_trigger_in;
    logic [CH*SW-1:0]     threshold_low;
    logic [CH*SW-1:0]     threshold_high;
    logic [CH*HW-1:0]     holdoff;
    logic [CH-1:0]        analog_en;
    logic [CH-1:0]        digital_en;
    logic [CH*SRCW-1:0]   digital_src;

    logic [CH*DW-1:0]     data_out;
    logic [CH-1:0]        data_out_valid;
    logic [CH*REC-1:0]    ts_out;
    logic [CH-1:0]        ts_out_valid;

    logic [CH*DW-1:0]     data_out_s;
    logic [CH-1:0]        data_out_valid_s;
    logic [CH*REC_S-1:0]  ts_out_s;
    logic [CH-1:0]        ts_out_valid_s;

    int n_checks = 0;
    int n_errors = 0;
    logic [TSW-1:0] tb_ts;

    always #5 adc_clk = ~adc_clk;

    sample_discriminator_multichannel #(
        .CHANNELS (CH), .TRIG_CHANNELS (TRIG), .SAMPLE_WIDTH (SW),
        .PARALLEL_SAMPLES (PS), .HOLDOFF_WIDTH (HW),
        .TIMESTAMP_WIDTH (TSW), .INDEX_WIDTH (IW)
    ) dut (
        .adc_clk (adc_clk), .adc_reset_n (adc_reset_n), .adc_reset_state (adc_reset_state),
        .data_in (data_in), .data_in_valid (data_in_valid),
        .digital_trigger_in (digital_trigger_in),
        .threshold_low (threshold_low), .threshold_high (threshold_high),
        .holdoff (holdoff), .analog_en (analog_en), .digital_en (digital_en),
        .digital_src (digital_src),
        .data_out (data_out), .data_out_valid (data_out_valid),
        .ts_out (ts_out), .ts_out_valid (ts_out_valid)
    );

    // Narrow-timestamp build sharing the same stimulus, used for the wrap check
    sample_discriminator_multichannel #(
        .CHANNELS (CH), .TRIG_CHANNELS (TRIG), .SAMPLE_WIDTH (SW),
        .PARALLEL_SAMPLES (PS), .HOLDOFF_WIDTH (HW),
        .TIMESTAMP_WIDTH (TSW_S), .INDEX_WIDTH (IW)
    ) dut_s (
        .adc_clk (adc_clk), .adc_reset_n (adc_reset_n), .adc_reset_state (adc_reset_state),
        .data_in (data_in), .data_in_valid (data_in_valid),
        .digital_trigger_in (digital_trigger_in),
        .threshold_low (threshold_low), .threshold_high (threshold_high),
        .holdoff (holdoff), .analog_en (analog_en), .digital_en (digital_en),
        .digital_src (digital_src),
        .data_out (data_out_s), .data_out_valid (data_out_valid_s),
        .ts_out (ts_out_s), .ts_out_valid (ts_out_valid_s)
    );

    typedef struct {
        logic          rs;
        logic          v;
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        logic [2:0]    trig;
        logic [SW-1:0] hi;
        logic [SW-1:0] lo;
        logic [HW-1:0] ho;
        logic          aen;
        logic          den;
        logic [1:0]    src;
        logic          exp_dv;
        logic          exp_tv;
        logic [IW-1:0] exp_idx;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int rs, input int v, input int s0, input int s1,
                                input int trig, input int hi, input int lo, input int ho,
                                input int aen, input int den, input int src,
                                input int dv, input int tv, input int idx);
        vec_t r;
        r.rs = 1'(rs);   r.v = 1'(v);
        r.s0 = SW'(s0);  r.s1 = SW'(s1);
        r.trig = 3'(trig);
        r.hi = SW'(hi);  r.lo = SW'(lo);  r.ho = HW'(ho);
        r.aen = 1'(aen); r.den = 1'(den); r.src = 2'(src);
        r.exp_dv = 1'(dv); r.exp_tv = 1'(tv); r.exp_idx = IW'(idx);
        return r;
    endfunction

    task automatic check(input string name, input logic [REC-1:0] act, input logic [REC-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge adc_clk);
        #1;
        if (adc_reset_state) tb_ts = '0;
        else                 tb_ts = tb_ts + 1'b1;
    endtask

    task automatic cfg_ch(input int c, input int hi, input int lo, input int ho,
                          input int aen, input int den, input int src);
        threshold_high[c*SW +: SW]  = SW'(hi);
        threshold_low[c*SW +: SW]   = SW'(lo);
        holdoff[c*HW +: HW]         = HW'(ho);
        analog_en[c]                = 1'(aen);
        digital_en[c]               = 1'(den);
        digital_src[c*SRCW +: SRCW] = SRCW'(src);
    endtask

    initial begin
        logic [DW-1:0]  last_word;
        logic [TSW-1:0] ts_at;
        logic [REC-1:0] rec0;
        logic [REC-1:0] rec1;

        //           rs v  s0   s1   trig  hi   lo  ho aen den src dv tv idx
        vecs[0]  = mk(0, 1, 150, 0,   0,   100, 20, 3, 1,  0,  0,  1, 1, 0);
        vecs[1]  = mk(0, 1, 0,   0,   0,   100, 20, 3, 1,  0,  0,  1, 0, 0);
        vecs[2]  = mk(0, 0, 0,   0,   0,   100, 20, 3, 1,  0,  0,  0, 0, 0);
        vecs[3]  = mk(0, 1, 0,   0,   0,   100, 20, 3, 1,  0,  0,  1, 0, 0);
        vecs[4]  = mk(0, 1, 0,   0,   0,   100, 20, 3, 1,  0,  0,  1, 0, 0);
        vecs[5]  = mk(0, 1, 0,   0,   0,   100, 20, 3, 1,  0,  0,  1, 0, 0);
        vecs[6]  = mk(0, 1, 0,   0,   0,   100, 20, 3, 1,  0,  0,  0, 0, 0);
        vecs[7]  = mk(0, 1, 0,   150, 0,   100, 20, 3, 1,  0,  0,  1, 1, 5);
        vecs[8]  = mk(1, 1, 150, 0,   0,   100, 20, 3, 1,  0,  0,  0, 0, 0);
        vecs[9]  = mk(0, 1, -20, 0,   0,   100, 20, 0, 1,  0,  0,  0, 0, 0);
        vecs[10] = mk(0, 1, 150, 0,   0,   100, 20, 0, 1,  0,  0,  1, 1, 0);
        vecs[11] = mk(0, 1, 60,  0,   0,   100, 20, 0, 1,  0,  0,  1, 0, 0);
        vecs[12] = mk(0, 1, 10,  0,   0,   100, 20, 0, 1,  0,  0,  1, 0, 0);
        vecs[13] = mk(0, 1, 10,  0,   0,   100, 20, 0, 1,  0,  0,  0, 0, 0);
        vecs[14] = mk(0, 1, -20, -30, 0,   -10, -50, 0, 1, 0,  0,  0, 0, 0);
        vecs[15] = mk(0, 1, -5,  -30, 0,   -10, -50, 0, 1, 0,  0,  1, 1, 3);
        vecs[16] = mk(0, 1, -40, -60, 0,   -10, -50, 0, 1, 0,  0,  1, 0, 0);
        vecs[17] = mk(0, 1, -60, -60, 0,   -10, -50, 0, 1, 0,  0,  1, 0, 0);
        vecs[18] = mk(0, 1, -60, -60, 0,   -10, -50, 0, 1, 0,  0,  0, 0, 0);
        vecs[19] = mk(0, 1, 150, 0,   1,   -10, -50, 0, 0, 1,  1,  0, 0, 0);
        vecs[20] = mk(0, 1, 0,   0,   2,   -10, -50, 0, 0, 1,  1,  1, 1, 6);
        vecs[21] = mk(0, 1, 0,   0,   2,   -10, -50, 0, 0, 1,  1,  1, 0, 0);
        vecs[22] = mk(0, 1, 0,   0,   0,   -10, -50, 0, 0, 1,  1,  1, 0, 0);
        vecs[23] = mk(0, 1, 0,   0,   0,   -10, -50, 0, 0, 1,  1,  0, 0, 0);
        vecs[24] = mk(0, 1, 0,   0,   7,   -10, -50, 0, 0, 1,  3,  0, 0, 0);
        vecs[25] = mk(0, 1, 0,   0,   7,   -10, -50, 0, 0, 1,  3,  0, 0, 0);
        vecs[26] = mk(0, 0, 0,   0,   2,   -10, -50, 0, 0, 1,  1,  0, 0, 0);
        vecs[27] = mk(0, 1, 5,   0,   2,   -10, -50, 0, 0, 1,  1,  1, 1, 9);
        vecs[28] = mk(0, 1, 0,   0,   0,   -10, -50, 0, 0, 1,  1,  1, 0, 0);

        adc_reset_n        = 1'b0;
        adc_reset_state    = 1'b0;
        data_in            = '0;
        data_in_valid      = '0;
        digital_trigger_in = '0;
        threshold_low      = '0;
        threshold_high     = '0;
        holdoff            = '0;
        analog_en          = '0;
        digital_en         = '0;
        digital_src        = '0;
        last_word          = '0;
        tb_ts              = '0;

        repeat (3) @(posedge adc_clk);
        #1;
        check("reset_dv", REC'(data_out_valid), '0);
        check("reset_tv", REC'(ts_out_valid), '0);
        check("reset_data", REC'(data_out), '0);
        adc_reset_n = 1'b1;
        tb_ts       = '0;

        // Channel 0 vector table; channel 1 stays invalid throughout
        for (int i = 0; i < NVEC; i++) begin
            cfg_ch(0, int'($signed(vecs[i].hi)), int'($signed(vecs[i].lo)), int'(vecs[i].ho),
                   int'(vecs[i].aen), int'(vecs[i].den), int'(vecs[i].src));
            adc_reset_state    = vecs[i].rs;
            data_in[DW-1:0]    = {vecs[i].s1, vecs[i].s0};
            data_in_valid      = {1'b0, vecs[i].v};
            digital_trigger_in = vecs[i].trig;
            ts_at = tb_ts;
            step();
            if (vecs[i].exp_dv) last_word = {vecs[i].s1, vecs[i].s0};
            check($sformatf("vec%0d_dv", i), REC'(data_out_valid[0]), REC'(vecs[i].exp_dv));
            check($sformatf("vec%0d_tv", i), REC'(ts_out_valid[0]), REC'(vecs[i].exp_tv));
            check($sformatf("vec%0d_data", i), REC'(data_out[DW-1:0]), REC'(last_word));
            check($sformatf("vec%0d_ch1_dv", i), REC'(data_out_valid[1]), '0);
            if (vecs[i].exp_tv) begin
                check($sformatf("vec%0d_ts", i), ts_out[REC-1:0], {ts_at, vecs[i].exp_idx});
            end
        end
        adc_reset_state    = 1'b0;
        digital_trigger_in = '0;

        // Open a window on ch0, then reset_state with a trigger on both channels
        cfg_ch(0, 100, 20, 5, 1, 0, 0);
        cfg_ch(1, 100, 20, 5, 1, 0, 0);
        data_in       = {12'd0, 12'd0, 12'd0, 12'd150};
        data_in_valid = 2'b01;
        ts_at = tb_ts;
        step();
        check("rs_pre_tv", REC'(ts_out_valid), REC'(2'b01));
        check("rs_pre_ts", ts_out[REC-1:0], {ts_at, 32'd11});

        adc_reset_state = 1'b1;
        data_in         = {12'd0, 12'd150, 12'd0, 12'd150};
        data_in_valid   = 2'b11;
        step();
        check("rs_dv", REC'(data_out_valid), '0);
        check("rs_tv", REC'(ts_out_valid), '0);

        adc_reset_state = 1'b0;
        data_in         = '0;
        data_in_valid   = 2'b11;
        step();
        check("rs_idle_dv", REC'(data_out_valid), '0);

        // Simultaneous starts on both channels after the clear
        data_in       = {12'd0, 12'd150, 12'd0, 12'd150};
        data_in_valid = 2'b11;
        ts_at = tb_ts;
        step();
        rec0 = ts_out[0*REC +: REC];
        rec1 = ts_out[1*REC +: REC];
        check("sim_tv", REC'(ts_out_valid), REC'(2'b11));
        check("sim_ts0", rec0, {ts_at, 32'd0});
        check("sim_ts1", rec1, {ts_at, 32'd0});
        check("sim_ts_at", REC'(ts_at), REC'(1));

        // Timestamp wrap on the narrow build: trigger 17 cycles after a clear
        adc_reset_state = 1'b1;
        data_in_valid   = '0;
        data_in         = '0;
        step();
        adc_reset_state = 1'b0;
        repeat (17) step();
        data_in       = {12'd0, 12'd0, 12'd0, 12'd150};
        data_in_valid = 2'b01;
        step();
        check("wrap_tv", REC'(ts_out_valid_s[0]), REC'(1));
        check("wrap_ts_narrow", REC'(ts_out_s[REC_S-1:0]), REC'({4'd1, 32'd0}));
        check("wrap_ts_wide", ts_out[REC-1:0], {48'd17, 32'd0});

        // Async reset in the middle of an open window
        data_in       = '0;
        data_in_valid = 2'b01;
        check("async_pre_dv", REC'(data_out_valid[0]), REC'(1));
        adc_reset_n = 1'b0;
        #1;
        check("async_dv", REC'(data_out_valid), '0);
        check("async_tv", REC'(ts_out_valid), '0);
        check("async_data", REC'(data_out), '0);
        @(posedge adc_clk);
        #1;
        adc_reset_n   = 1'b1;
        tb_ts         = '0;
        data_in       = {12'd0, 12'd0, 12'd0, 12'd150};
        data_in_valid = 2'b01;
        step();
        check("async_restart_tv", REC'(ts_out_valid[0]), REC'(1));
        check("async_restart_ts", ts_out[REC-1:0], {48'd0, 32'd0});
        check("async_restart_data", REC'(data_out[DW-1:0]), REC'({12'd0, 12'd150}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sample_discriminator_multichannel
